// File: rtl/reg_alu_sequencer_pkg.sv
// Shared definitions for the register-file/ALU sequencer: instruction layout,
// carry-mode codes, FSM states and the carry-in selection helper.
package reg_alu_sequencer_pkg;

  localparam int INSTR_W = 24;
  localparam int ADDR_W  = 4;
  localparam int REP_W   = 4;
  localparam int FUNC_W  = 3;

  typedef enum logic [1:0] {
    CMODE_ZERO = 2'b00,
    CMODE_ONE  = 2'b01,
    CMODE_FLAG = 2'b10,
    CMODE_RSVD = 2'b11
  } cmode_e;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_e;

  // Member order mirrors the instruction word, MSB first.
  typedef struct packed {
    logic [REP_W-1:0]  rep;
    logic [FUNC_W-1:0] func;
    cmode_e            cmode;
    logic              sel;
    logic              wen;
    logic              inc;
    logic [ADDR_W-1:0] dest;
    logic [ADDR_W-1:0] left;
    logic [ADDR_W-1:0] right;
  } instr_t;

  function automatic logic carrySelect(input cmode_e mode, input logic flag);
    logic c;
    c = 1'b0;
    case (mode)
      CMODE_ONE:  c = 1'b1;
      CMODE_FLAG: c = flag;
      default:    c = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/reg_alu_sequencer_decode.sv
// Combinational decode: splits the raw instruction into named fields and
// picks the ALU carry input from the held carry mode.
module reg_alu_sequencer_decode
  import reg_alu_sequencer_pkg::*;
(
  input  logic [INSTR_W-1:0] instr_i,
  input  cmode_e             cmode_i,
  input  logic               flag_i,
  output instr_t             fields_o,
  output logic               crIn_o
);

  assign fields_o = instr_t'(instr_i);
  assign crIn_o   = carrySelect(cmode_i, flag_i);

endmodule

// File: rtl/reg_alu_sequencer.sv
// Control stage for the register-file/ALU datapath: accepts micro-instructions,
// repeats them with optional address auto-increment and chains the ALU carry.
module reg_alu_sequencer
  import reg_alu_sequencer_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [DATA_W-1:0]  data_in,
  input  logic               data_valid,
  output logic               data_ready,
  output logic [FUNC_W-1:0]  func,
  output logic               crIn,
  output logic [ADDR_W-1:0]  leftAddr,
  output logic [ADDR_W-1:0]  rightAddr,
  output logic [ADDR_W-1:0]  destAddr,
  output logic               writeEn,
  output logic               selInput,
  output logic [DATA_W-1:0]  dataIn,
  input  logic               crOut,
  output logic               busy,
  output logic               carry_flag
);

  state_e            state_q, state_d;
  logic [REP_W-1:0]  cnt_q, cnt_d;
  logic [FUNC_W-1:0] func_q, func_d;
  cmode_e            cmode_q, cmode_d;
  logic              sel_q, sel_d;
  logic              wen_q, wen_d;
  logic              inc_q, inc_d;
  logic [ADDR_W-1:0] dest_q, dest_d;
  logic [ADDR_W-1:0] left_q, left_d;
  logic [ADDR_W-1:0] right_q, right_d;
  logic              carry_q, carry_d;

  instr_t dec;
  logic   issue, lastIssue, accept;

  reg_alu_sequencer_decode u_decode (
    .instr_i  (instr_in),
    .cmode_i  (cmode_q),
    .flag_i   (carry_q),
    .fields_o (dec),
    .crIn_o   (crIn)
  );

  // An instruction that reads dataIn may only issue when an operand word is present;
  // everything that has an effect is gated by reset so an aborted iteration never writes.
  assign issue       = (state_q == EXEC) && (!sel_q || data_valid) && !reset;
  assign lastIssue   = issue && (cnt_q == '0);
  assign instr_ready = !reset && ((state_q == IDLE) || lastIssue);
  assign accept      = instr_valid && instr_ready;

  assign writeEn    = issue && wen_q;
  assign data_ready = issue && sel_q;
  assign busy       = (state_q != IDLE) && !reset;
  assign func       = func_q;
  assign selInput   = sel_q;
  assign destAddr   = dest_q;
  assign leftAddr   = left_q;
  assign rightAddr  = right_q;
  assign dataIn     = data_in;
  assign carry_flag = carry_q;

  // A new instruction accepted on the last issue overrides the iteration update,
  // giving back-to-back execution without an idle cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    func_d  = func_q;
    cmode_d = cmode_q;
    sel_d   = sel_q;
    wen_d   = wen_q;
    inc_d   = inc_q;
    dest_d  = dest_q;
    left_d  = left_q;
    right_d = right_q;
    carry_d = carry_q;
    if (issue) begin
      carry_d = crOut;
      if (inc_q) begin
        dest_d  = dest_q + ADDR_W'(1);
        left_d  = left_q + ADDR_W'(1);
        right_d = right_q + ADDR_W'(1);
      end
      if (lastIssue) begin
        state_d = IDLE;
      end else begin
        cnt_d = cnt_q - REP_W'(1);
      end
    end
    if (accept) begin
      state_d = EXEC;
      cnt_d   = dec.rep;
      func_d  = dec.func;
      cmode_d = dec.cmode;
      sel_d   = dec.sel;
      wen_d   = dec.wen;
      inc_d   = dec.inc;
      dest_d  = dec.dest;
      left_d  = dec.left;
      right_d = dec.right;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      func_q  <= '0;
      cmode_q <= CMODE_ZERO;
      sel_q   <= 1'b0;
      wen_q   <= 1'b0;
      inc_q   <= 1'b0;
      dest_q  <= '0;
      left_q  <= '0;
      right_q <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      func_q  <= func_d;
      cmode_q <= cmode_d;
      sel_q   <= sel_d;
      wen_q   <= wen_d;
      inc_q   <= inc_d;
      dest_q  <= dest_d;
      left_q  <= left_d;
      right_q <= right_d;
      carry_q <= carry_d;
    end
  end

endmodule
